intt_seq: RTL and testbench
===========================

Name: intt_seq

Overview:
- Sequential Kyber inverse NTT engine. Accepts the 256 NTT-domain coefficients produced by the base-case multiply stage and returns the normal-domain polynomial.
- Computes NTT^-1 per FIPS 203 Alg. 10, using Gentleman-Sande butterflies, one butterfly per cycle, over an internal 256-entry register array.
- Final scaling by 128^-1 = 3303 mod 3329 is applied on the output stream.
- Sits between NTT-domain multiply/accumulate and compress/encode.

Parameters:
- SCALE_EN, 1: 1 multiplies each output by 3303 mod q. 0 outputs raw butterfly results (test/debug only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  engine accepts input (LOAD state).
- in_data  in  12  NTT-domain coefficient, index order 0..255.
- out_valid  out  1  output coefficient valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  12  normal-domain coefficient, index order 0..255, always < 3329.
- busy  out  1  high in COMPUTE or OUTPUT.

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising clk).
- Reset values: state=LOAD, idx=0, in_ready=1, out_valid=0, out_data=0, busy=0. Array contents are don't-care.
- Handshake: transfer occurs when valid&&ready on a rising edge. Valid must not depend on ready. out_data is held stable while out_valid&&!out_ready.
- LOAD:
  - in_ready=1. Each transfer writes f[idx] = (in_data>=3329) ? in_data-3329 : in_data, then idx++.
  - The transfer with idx==255 moves the engine to COMPUTE, and in_ready drops in the next cycle.
- COMPUTE:
  - in_ready=0, out_valid=0. Counters: len in {2,4,...,128}, start, j, k. Init len=2, k=127.
  - Per cycle (one butterfly): t=f[j]; u=f[j+len]; f[j]=(t+u) mod q; f[j+len]=zeta[k]*((u-t) mod q) mod q.
  - j++ within the group. At the group end: start+=2*len, k--. At start==256: len*=2, start=0.
  - Exactly 7*128=896 cycles, then OUTPUT.
  - Subtraction: (u-t) computed as u+q-t, then conditional subtract. Add: conditional subtract of q.
- OUTPUT:
  - out_valid=1, out_data = SCALE_EN ? (f[idx]*3303 mod q) : f[idx] (registered).
  - idx advances on each transfer. The transfer with idx==255 returns to LOAD with idx=0. out_valid=0 and in_ready=1 in the next cycle.
- Latency: first out_valid cycle is 897 cycles after the edge accepting input 255. No backpressure stall occurs before OUTPUT.
- Modular multiply: 12x12 -> 24-bit product, reduced to [0,q) exactly. Barrett reduction with final conditional subtract.
- Inputs in [3329,4095] are reduced once on load. No other input checking.
- rst during any state aborts the current polynomial and returns to reset values. Partial data is discarded.
- in_valid while not LOAD is ignored (in_ready=0). out_ready while out_valid=0 is ignored.

Decomposition:
- Package kyber_pkg:
  - KYBER_Q=3329, KYBER_N=256, COEF_W=12, N_INV=3303.
  - typedef coef_t (logic [11:0]).
  - ZETAS[0:127] = 17^BitRev7(i) mod q. ZETAS[0]=1, ZETAS[1]=1729, ZETAS[126]=885, ZETAS[127]=2154.
  - state enum {LOAD, COMPUTE, OUTPUT}.
- Sub-module mod_mul_q: combinational (a,b)->a*b mod 3329. Instantiated twice, once for the butterfly and once for the output scale.

Test Plan:
- Load 256 zeros -> 256 zero outputs; first out_valid exactly 897 cycles after the last input edge.
- Load pairs (1,0) x128, i.e. NTT(1) -> out[0]=1, out[1..255]=0.
- Load pairs (0,1) x128, i.e. NTT(x) -> out[1]=1, all others 0. Repeat with SCALE_EN=0 -> out[1]=128, all others 0.
- Random a<q: load NTT(a) from the golden model -> output equals a bit-exactly. Also load in_data=3329+r for one coefficient and check it matches loading r.
- Random out_ready (~40% duty) and gapped in_valid -> no lost or duplicated coefficients; out_data stable while stalled. Back-to-back polynomials run correctly.
- Assert rst at COMPUTE cycle 400 -> next cycle in_ready=1, busy=0, out_valid=0. A fresh polynomial then completes correctly.

Source files
------------

// File: rtl/kyber_pkg.sv
// Kyber constants, coefficient type, zeta table and modular add/sub helpers
// shared by the inverse NTT engine and its multiplier.
package kyber_pkg;
    localparam int KYBER_Q   = 3329;
    localparam int KYBER_N   = 256;
    localparam int COEF_W    = 12;
    localparam int N_INV     = 3303;
    localparam int BARRETT_M = 5039;  // floor(2^24 / q)

    typedef logic [COEF_W-1:0] coef_t;
    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

    // 17^BitRev7(i) mod q
    localparam coef_t ZETAS [0:127] = '{
        12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
        12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
        12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
        12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
        12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
        12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
        12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
        12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
        12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
        12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
        12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
        12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
        12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
        12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
        12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
        12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
    };

    function automatic coef_t add_q(input coef_t a, input coef_t b);
        logic [COEF_W:0] s;
        s = (COEF_W+1)'(a) + (COEF_W+1)'(b);
        return (s >= (COEF_W+1)'(KYBER_Q)) ? coef_t'(s - (COEF_W+1)'(KYBER_Q)) : s[COEF_W-1:0];
    endfunction

    // a - b, formed as a + q - b so the intermediate never goes negative
    function automatic coef_t sub_q(input coef_t a, input coef_t b);
        logic [COEF_W:0] s;
        s = (COEF_W+1)'(a) + (COEF_W+1)'(KYBER_Q) - (COEF_W+1)'(b);
        return (s >= (COEF_W+1)'(KYBER_Q)) ? coef_t'(s - (COEF_W+1)'(KYBER_Q)) : s[COEF_W-1:0];
    endfunction
endpackage

// File: rtl/mod_mul_q.sv
// Combinational a*b mod q using Barrett reduction (k=24); both operands must be < q.
module mod_mul_q
    import kyber_pkg::*;
(
    input  coef_t a,
    input  coef_t b,
    output coef_t p
);
    logic [23:0] prod;
    logic [12:0] quo;
    logic [12:0] rem;

    assign prod = 24'(a) * 24'(b);
    // The quotient estimate is low by at most one, so rem lies in [0, 2q)
    assign quo  = 13'((37'(prod) * 37'(BARRETT_M)) >> 24);
    assign rem  = 13'(prod - 24'(quo) * 24'(KYBER_Q));
    assign p    = (rem >= 13'(KYBER_Q)) ? coef_t'(rem - 13'(KYBER_Q)) : rem[COEF_W-1:0];
endmodule

// File: rtl/intt_seq.sv
// Sequential Kyber inverse NTT: loads 256 NTT-domain coefficients, runs one
// Gentleman-Sande butterfly per cycle, then streams out the scaled result.
module intt_seq
    import kyber_pkg::*;
#(
    parameter bit SCALE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_data,
    output logic              busy
);
    state_t     state;
    logic [7:0] idx, len, start, j, jl, rd_idx;
    logic [6:0] k;
    logic [8:0] next_start;
    logic       group_end;
    coef_t      f [0:KYBER_N-1];
    coef_t      t, u, zeta, sum_q, diff_q, bf_prod, rd_coef, scaled, in_red;

    assign jl         = j + len;
    assign t          = f[j];
    assign u          = f[jl];
    assign zeta       = ZETAS[k];
    assign sum_q      = add_q(t, u);
    assign diff_q     = sub_q(u, t);
    assign group_end  = (j + 8'd1) == (start + len);
    assign next_start = {1'b0, start} + {len, 1'b0};
    assign in_red     = (in_data >= coef_t'(KYBER_Q)) ? coef_t'(in_data - coef_t'(KYBER_Q)) : in_data;

    // Output register preloads the coefficient it will present after the current transfer
    assign rd_idx  = out_valid ? idx + 8'd1 : idx;
    assign rd_coef = f[rd_idx];

    mod_mul_q u_bf_mul (.a(zeta),    .b(diff_q),         .p(bf_prod));
    mod_mul_q u_scale  (.a(rd_coef), .b(coef_t'(N_INV)), .p(scaled));

    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid && in_ready) begin
            f[idx] <= in_red;
        end else if (state == COMPUTE) begin
            f[j]  <= sum_q;
            f[jl] <= bf_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            len       <= 8'd2;
            start     <= '0;
            j         <= '0;
            k         <= 7'd127;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        if (idx == 8'd255) begin
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            len      <= 8'd2;
                            start    <= '0;
                            j        <= '0;
                            k        <= 7'd127;
                        end
                        idx <= idx + 8'd1;
                    end
                end
                COMPUTE: begin
                    if (group_end) begin
                        k <= k - 7'd1;
                        if (next_start[8]) begin
                            if (len == 8'd128) begin
                                state <= OUTPUT;
                                idx   <= '0;
                            end
                            len   <= {len[6:0], 1'b0};
                            start <= '0;
                            j     <= '0;
                        end else begin
                            start <= next_start[7:0];
                            j     <= next_start[7:0];
                        end
                    end else begin
                        j <= j + 8'd1;
                    end
                end
                OUTPUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= SCALE_EN ? scaled : rd_coef;
                    end else if (out_ready) begin
                        if (idx == 8'd255) begin
                            state     <= LOAD;
                            idx       <= '0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            idx      <= idx + 8'd1;
                            out_data <= SCALE_EN ? scaled : rd_coef;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_intt_seq.sv
// Self-checking bench for intt_seq: stimulus is the forward NTT of a known
// polynomial, so the expected output is that polynomial (x128 when unscaled).
module tb_intt_seq;
    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] in_data;
    logic        out_ready;
    logic        in_ready, out_valid, busy;
    logic [11:0] out_data;
    logic        in_ready1, out_valid1, busy1;
    logic [11:0] out_data1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int e0_cyc = 0;
    int zetas [128];
    int poly  [256];
    int drv   [256];
    int exp_s [256];
    int exp_r [256];

    intt_seq #(.SCALE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    intt_seq #(.SCALE_EN(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bitrev7(input int x);
        int r = 0;
        for (int b = 0; b < 7; b++) if ((x >> b) & 1) r |= 1 << (6 - b);
        return r;
    endfunction

    function automatic int powmod(input int base, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * base) % Q;
        return r;
    endfunction

    // Forward NTT (FIPS 203 Alg. 9) of poly into drv; expected outputs follow from poly
    task automatic ntt_of_poly();
        int f [256];
        int zi;
        int z;
        int t;
        f  = poly;
        zi = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                z = zetas[zi];
                zi++;
                for (int jj = st; jj < st + len; jj++) begin
                    t           = (z * f[jj + len]) % Q;
                    f[jj + len] = (f[jj] - t + Q) % Q;
                    f[jj]       = (f[jj] + t) % Q;
                end
            end
        end
        drv = f;
        for (int i = 0; i < 256; i++) begin
            exp_s[i] = poly[i];
            exp_r[i] = (poly[i] * 128) % Q;
        end
    endtask

    task automatic random_poly();
        for (int i = 0; i < 256; i++) poly[i] = $urandom_range(0, Q - 1);
        ntt_of_poly();
    endtask

    task automatic load_poly(input bit gaps, input int count);
        int n = 0;
        int budget = 0;
        bit xfer;
        while (n < count && budget < 4000) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 12'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = 12'(drv[n]);
            end
            xfer = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (xfer) n++;
            budget++;
        end
        e0_cyc   = cyc;
        in_valid = 1'b0;
        in_data  = 12'($urandom);
        checks++;
        if (n != count) begin
            errors++;
            $display("FAIL load_count: accepted %0d, required %0d", n, count);
        end
        if (count == 256) begin
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL load_exit: in_ready=%b busy=%b out_valid=%b, required 0 1 0",
                         in_ready, busy, out_valid);
            end
        end
    endtask

    task automatic drain_poly(input int pct, input bit junk);
        int got = 0;
        int budget = 0;
        bit xfer;
        bit stalled = 1'b0;
        bit first = 1'b1;
        logic [11:0] held_s = '0;
        logic [11:0] held_r = '0;
        while (got < 256 && budget < 6000) begin
            out_ready = ($urandom_range(0, 99) < pct);
            in_valid  = junk && (got < 255);
            in_data   = 12'($urandom);
            if (out_valid && first) begin
                first = 1'b0;
                checks++;
                if (cyc - e0_cyc != 897) begin
                    errors++;
                    $display("FAIL latency: first out_valid %0d cycles after last input, required 897",
                             cyc - e0_cyc);
                end
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_s || out_data1 !== held_r) begin
                    errors++;
                    $display("FAIL hold[%0d]: valid=%b data=%0d/%0d, required 1 %0d/%0d",
                             got, out_valid, out_data, out_data1, held_s, held_r);
                end
            end
            xfer = out_valid && out_ready;
            if (xfer) begin
                checks++;
                if (out_data !== 12'(exp_s[got])) begin
                    errors++;
                    $display("FAIL out_scaled[%0d]: got %0d, required %0d", got, out_data, exp_s[got]);
                end
                checks++;
                if (out_valid1 !== 1'b1 || out_data1 !== 12'(exp_r[got])) begin
                    errors++;
                    $display("FAIL out_raw[%0d]: valid=%b got %0d, required 1 %0d",
                             got, out_valid1, out_data1, exp_r[got]);
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held_s  = out_data;
            held_r  = out_data1;
            @(posedge clk);
            #1;
            budget++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (got != 256) begin
            errors++;
            $display("FAIL drain_count: received %0d, required 256", got);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%0d busy=%b, required 1 0 0 0",
                     in_ready, out_valid, out_data, busy);
        end
        checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || out_data1 !== 12'd0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_raw: in_ready=%b out_valid=%b out_data=%0d busy=%b, required 1 0 0 0",
                     in_ready1, out_valid1, out_data1, busy1);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        for (int i = 0; i < 256; i++) poly[i] = 0;
        ntt_of_poly();
        load_poly(1'b0, 256);
        drain_poly(100, 1'b0);
    endtask

    task automatic test_ntt_one();
        for (int i = 0; i < 256; i++) begin
            drv[i]   = (i % 2 == 0) ? 1 : 0;
            exp_s[i] = (i == 0) ? 1 : 0;
            exp_r[i] = (i == 0) ? 128 : 0;
        end
        load_poly(1'b0, 256);
        drain_poly(100, 1'b0);
    endtask

    task automatic test_ntt_x();
        for (int i = 0; i < 256; i++) begin
            drv[i]   = (i % 2 == 1) ? 1 : 0;
            exp_s[i] = (i == 1) ? 1 : 0;
            exp_r[i] = (i == 1) ? 128 : 0;
        end
        load_poly(1'b0, 256);
        drain_poly(100, 1'b0);
    endtask

    // Random polynomial with aliased (>= q) inputs, gapped input and throttled output
    task automatic test_random_alias();
        int base;
        int i;
        bit done;
        for (int rep = 0; rep < 3; rep++) begin
            random_poly();
            base = $urandom_range(0, 255);
            done = 1'b0;
            for (int m = 0; m < 256; m++) begin
                i = (base + m) % 256;
                if (drv[i] <= 4095 - Q && (!done || $urandom_range(0, 3) == 0)) begin
                    drv[i] += Q;
                    done = 1'b1;
                end
            end
            load_poly(1'b1, 256);
            drain_poly(40, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int rep = 0; rep < 2; rep++) begin
            random_poly();
            load_poly(1'b0, 256);
            drain_poly(100, 1'b0);
        end
    endtask

    task automatic test_abort();
        random_poly();
        load_poly(1'b0, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_poly(1'b0, 256);
        repeat (399) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort: in_ready=%b busy=%b out_valid=%b, required 1 0 0",
                     in_ready, busy, out_valid);
        end
        random_poly();
        load_poly(1'b1, 256);
        drain_poly(60, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 128; i++) zetas[i] = powmod(17, bitrev7(i));
        test_reset();
        test_zero();
        test_ntt_one();
        test_ntt_x();
        test_random_alias();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
